// File: rtl/swerv_trace_serializer.sv
// -----------------------------------------------------------------------------
// swerv_trace_serializer
//
// Purpose: collects the core's three-lane retirement trace packet into a FIFO
// of per-instruction records. Records leave one per cycle on a valid/ready
// port. A packet that does not fit in the free space is dropped whole. Drops
// set a sticky overflow flag and are counted in a saturating counter.
//
// Optional feature (macro TRACE_TIMESTAMP_EN): a 32-bit free-running cycle
// counter. Each record stores the counter value of its push cycle, and the
// head record's value is presented on out_ts.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   in_valid[2:0]       per-lane retire valid, lane 0 oldest
//   in_insn/in_addr     3 x 32-bit lane instruction / PC
//   in_exc/in_intr      per-lane exception / interrupt flags
//   in_ecause, in_tval  shared cause and trap value
//   out_valid/out_ready head record handshake
//   out_insn..out_tval  head record fields (out_ts when timestamps enabled)
//   level               current occupancy
//   overflow, drop_cnt  sticky drop flag and dropped-packet count
//   clr_overflow        clears overflow and drop_cnt
// -----------------------------------------------------------------------------
module swerv_trace_serializer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               in_valid,
  input  logic [95:0]              in_insn,
  input  logic [95:0]              in_addr,
  input  logic [2:0]               in_exc,
  input  logic [2:0]               in_intr,
  input  logic [4:0]               in_ecause,
  input  logic [31:0]              in_tval,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_insn,
  output logic [31:0]              out_addr,
  output logic                     out_exc,
  output logic                     out_intr,
  output logic [4:0]               out_ecause,
  output logic [31:0]              out_tval,
`ifdef TRACE_TIMESTAMP_EN
  output logic [31:0]              out_ts,
`endif
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [31:0] insn_mem   [DEPTH];
  logic [31:0] addr_mem   [DEPTH];
  logic        exc_mem    [DEPTH];
  logic        intr_mem   [DEPTH];
  logic [4:0]  ecause_mem [DEPTH];
  logic [31:0] tval_mem   [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [1:0]    n;
  logic [LW-1:0] free;
  logic          fits;
  logic          push;
  logic          drop;
  logic          pop;
  logic [PW-1:0] slot [3];

  // Admission compares against occupancy before this cycle's pop, so a
  // same-cycle pop never makes room for the incoming packet.
  always_comb begin
    n    = {1'b0, in_valid[0]} + {1'b0, in_valid[1]} + {1'b0, in_valid[2]};
    free = LW'(DEPTH) - level_q;
    fits = LW'(n) <= free;
    push = (n != 2'd0) && fits;
    drop = (n != 2'd0) && !fits;
    pop  = (level_q != '0) && out_ready;
  end

  // Valid lanes are packed into consecutive slots; each lane's offset is the
  // number of valid lanes below it.
  always_comb begin
    slot[0] = wr_ptr_q;
    slot[1] = wr_ptr_q + PW'({1'b0, in_valid[0]});
    slot[2] = wr_ptr_q + PW'({1'b0, in_valid[0]} + {1'b0, in_valid[1]});
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + (push ? PW'(n) : '0);
    rd_ptr_d = rd_ptr_q + (pop ? PW'(1) : '0);
    level_d  = level_q + (push ? LW'(n) : '0) - (pop ? LW'(1) : '0);
  end

  // A drop in the same cycle as a clear wins and restarts the count at 1.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_overflow) begin
        drop_cnt_d = CNT_W'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; the outputs are gated by out_valid so stale
  // contents never appear after reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (push && in_valid[k]) begin
        insn_mem[slot[k]]   <= in_insn[32*k +: 32];
        addr_mem[slot[k]]   <= in_addr[32*k +: 32];
        exc_mem[slot[k]]    <= in_exc[k];
        intr_mem[slot[k]]   <= in_intr[k];
        ecause_mem[slot[k]] <= (in_exc[k] | in_intr[k]) ? in_ecause : 5'd0;
        tval_mem[slot[k]]   <= (in_exc[k] | in_intr[k]) ? in_tval : 32'd0;
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] ts_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (push && in_valid[k]) begin
        ts_mem[slot[k]] <= ts_q;
      end
    end
  end

  assign out_ts = out_valid ? ts_mem[rd_ptr_q] : 32'd0;
`endif

  assign out_valid  = (level_q != '0);
  assign out_insn   = out_valid ? insn_mem[rd_ptr_q]   : 32'd0;
  assign out_addr   = out_valid ? addr_mem[rd_ptr_q]   : 32'd0;
  assign out_exc    = out_valid ? exc_mem[rd_ptr_q]    : 1'b0;
  assign out_intr   = out_valid ? intr_mem[rd_ptr_q]   : 1'b0;
  assign out_ecause = out_valid ? ecause_mem[rd_ptr_q] : 5'd0;
  assign out_tval   = out_valid ? tval_mem[rd_ptr_q]   : 32'd0;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_swerv_trace_serializer.sv
module tb_swerv_trace_serializer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_valid;
  logic [95:0] in_insn;
  logic [95:0] in_addr;
  logic [2:0]  in_exc;
  logic [2:0]  in_intr;
  logic [4:0]  in_ecause;
  logic [31:0] in_tval;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic [31:0] out_addr;
  logic        out_exc;
  logic        out_intr;
  logic [4:0]  out_ecause;
  logic [31:0] out_tval;
  logic [3:0]  level;
  logic        overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic        clr_overflow;

  swerv_trace_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_insn(in_insn), .in_addr(in_addr),
    .in_exc(in_exc), .in_intr(in_intr), .in_ecause(in_ecause), .in_tval(in_tval),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_addr(out_addr), .out_exc(out_exc), .out_intr(out_intr),
    .out_ecause(out_ecause), .out_tval(out_tval),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt),
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
  } rec_t;

  rec_t         mq[$];
  logic         m_ovf;
  int unsigned  m_cnt;
  int           n_vec;
  int           n_err;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [127:0] pk(input rec_t r);
    return {25'd0, r.insn, r.addr, r.exc, r.intr, r.ecause, r.tval};
  endfunction

  // Reference model: a queue of records, one step per clock edge.
  task automatic model_step();
    int   n;
    bit   do_pop;
    rec_t r;
    n = $countones(in_valid);
    do_pop = (mq.size() != 0) && out_ready;
    if (n > 0 && n > DEPTH - mq.size()) begin
      m_ovf = 1'b1;
      if (clr_overflow) m_cnt = 1;
      else if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else begin
      if (clr_overflow) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end
      if (do_pop) void'(mq.pop_front());
      do_pop = 0;
      for (int k = 0; k < 3; k++) begin
        if (in_valid[k]) begin
          r.insn   = in_insn[32*k +: 32];
          r.addr   = in_addr[32*k +: 32];
          r.exc    = in_exc[k];
          r.intr   = in_intr[k];
          r.ecause = (in_exc[k] || in_intr[k]) ? in_ecause : 5'd0;
          r.tval   = (in_exc[k] || in_intr[k]) ? in_tval : 32'd0;
          mq.push_back(r);
        end
      end
    end
    if (do_pop) void'(mq.pop_front());
  endtask

  task automatic check_all();
    chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
    chk("level", 128'(level), 128'(mq.size()));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_cnt));
    if (mq.size() != 0)
      chk("head_rec", {25'd0, out_insn, out_addr, out_exc, out_intr, out_ecause, out_tval},
          pk(mq[0]));
  endtask

  task automatic cycle(input logic [2:0] v, input logic [95:0] insn, input logic [95:0] addr,
                       input logic [2:0] exc, input logic [2:0] intr, input logic [4:0] ec,
                       input logic [31:0] tv, input logic rdy, input logic clr);
    in_valid = v; in_insn = insn; in_addr = addr; in_exc = exc; in_intr = intr;
    in_ecause = ec; in_tval = tv; out_ready = rdy; clr_overflow = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic rdy);
    cycle(3'b000, 96'd0, 96'd0, 3'b000, 3'b000, 5'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic push3(input logic rdy, input logic clr);
    cycle(3'b111, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
          3'b000, 3'b000, 5'd0, 32'd0, rdy, clr);
  endtask

  task automatic rnd_cycle();
    cycle(3'($urandom), {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
          3'($urandom), 3'($urandom), 5'($urandom), $urandom,
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_ovf = 1'b0; m_cnt = 0;
    rst = 1'b1; in_valid = '0; in_insn = '0; in_addr = '0; in_exc = '0; in_intr = '0;
    in_ecause = '0; in_tval = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {out_valid, level, overflow, drop_cnt, out_insn, out_addr,
                        out_exc, out_intr, out_ecause, out_tval}, 128'd0);
    rst = 1'b0;

    // Three lanes in order, drained one per cycle.
    cycle(3'b111, 96'd0, {32'h108, 32'h104, 32'h100}, 3'b000, 3'b000, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("plan_addr0", 128'(out_addr), 128'h100);
    idle(1'b1);
    chk("plan_addr1", 128'(out_addr), 128'h104);
    idle(1'b1);
    chk("plan_addr2", 128'(out_addr), 128'h108);
    idle(1'b1);
    chk("plan_empty", 128'(level), 128'd0);

    // Sparse lanes with a trap on lane 2.
    cycle(3'b101, {32'h00100073, 32'h0, 32'h00000013}, {32'h208, 32'h204, 32'h200},
          3'b100, 3'b000, 5'd3, 32'hDEAD, 1'b0, 1'b0);
    idle(1'b1);
    chk("trap_rec", {out_insn, out_exc, out_ecause, out_tval},
        {32'h00100073, 1'b1, 5'd3, 32'hDEAD});
    idle(1'b1);

    // Back-pressure: third packet dropped whole, outputs held.
    push3(1'b0, 1'b0);
    push3(1'b0, 1'b0);
    push3(1'b0, 1'b0);
    chk("bp_level", 128'(level), 128'd6);
    chk("bp_drop", 128'(drop_cnt), 128'd1);
    repeat (3) idle(1'b0);

    // level 7: push 1 with pop accepted, then push 2 with pop dropped.
    cycle(3'b010, {$urandom, $urandom, $urandom}, 96'd0, 3'b000, 3'b000, 5'd0, 32'd0, 1'b0, 1'b0);
    cycle(3'b100, {$urandom, $urandom, $urandom}, 96'd0, 3'b000, 3'b000, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("pp_level", 128'(level), 128'd7);
    cycle(3'b011, {$urandom, $urandom, $urandom}, 96'd0, 3'b000, 3'b000, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("pp_drop", 128'(drop_cnt), 128'd2);

    // Build drop_cnt to 5, then drop together with clear, then clear alone.
    repeat (3) push3(1'b0, 1'b0);
    chk("cnt5", 128'(drop_cnt), 128'd5);
    push3(1'b0, 1'b1);
    chk("drop_wins", 128'({overflow, drop_cnt}), 128'({1'b1, 16'd1}));
    cycle(3'b000, 96'd0, 96'd0, 3'b000, 3'b000, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("clr_alone", 128'({overflow, drop_cnt}), 128'd0);
    repeat (DEPTH) idle(1'b1);

    for (int i = 0; i < 400; i++) rnd_cycle();

    // Asynchronous reset mid-stream.
    push3(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 128'({out_valid, level}), 128'd0);
    mq.delete(); m_ovf = 1'b0; m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) rnd_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
